// File: rtl/abs_sched_pkg.sv
// Shared types and the round-robin pick helper for the abs stream scheduler.
package abs_sched_pkg;

  localparam int unsigned MaxCh = 32;

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StWarm,
    StRun,
    StDone
  } sched_state_t;

  // First set request at or after ptr (wrapping at nch); returns the found flag.
  function automatic logic rr_pick(input logic [MaxCh-1:0] req, input int unsigned nch,
                                   input int unsigned ptr, output int unsigned idx);
    logic        found;
    int unsigned j;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < MaxCh; i++) begin
      j = ptr + i;
      if (j >= nch) j = j - nch;
      if (i < nch && !found && req[j[4:0]]) begin
        found = 1'b1;
        idx   = j;
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/abs_stream_sched_if.sv
// Requester/result bus of the abs stream scheduler.
// Optional neg output is present when ABS_SCHED_SIGN_OUT_EN is defined.
interface abs_stream_sched_if #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned LOG_LEN = 8
);
  localparam int unsigned ChW = $clog2(NCH);

  logic [NCH-1:0]   req;
  logic [NCH-1:0]   value;
  logic [NCH-1:0]   gnt;
  logic             abs_bit;
  logic             busy;
  logic             done;
  logic [ChW-1:0]   done_ch;
  logic [LOG_LEN:0] result;
`ifdef ABS_SCHED_SIGN_OUT_EN
  logic             neg;
`endif

  modport master (
    output req, value,
    input  gnt, abs_bit, busy, done, done_ch, result
`ifdef ABS_SCHED_SIGN_OUT_EN
    , input neg
`endif
  );

  modport slave (
    input  req, value,
    output gnt, abs_bit, busy, done, done_ch, result
`ifdef ABS_SCHED_SIGN_OUT_EN
    , output neg
`endif
  );

endinterface

// File: rtl/abs_sign_est.sv
// Sign estimator for a bipolar bitstream: saturating up/down counter, abs = value ^ sign.
module abs_sign_est #(
  parameter int unsigned DEP = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic value,
  output logic sign,
  output logic abs
);

  localparam logic [DEP-1:0] Mid = DEP'(1) << (DEP - 1);

  logic [DEP-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = Mid;
    end else if (en) begin
      if (value && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
      else if (!value && (|cnt_q)) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= Mid;
    else        cnt_q <= cnt_d;
  end

  // Upper half of the counter means the stream is mostly ones, i.e. non-negative.
  assign sign = ~cnt_q[DEP-1];
  assign abs  = value ^ sign;

endmodule

// File: rtl/abs_stream_sched.sv
// Round-robin scheduler sharing one abs kernel between NCH bitstream requesters.
// Define ABS_SCHED_SIGN_OUT_EN to add the neg output and its sign counter.
module abs_stream_sched
  import abs_sched_pkg::*;
#(
  parameter int unsigned NCH     = 4,
  parameter int unsigned LOG_LEN = 8,
  parameter int unsigned WARM    = 8,
  parameter int unsigned DEP     = 3
) (
  input logic               clk,
  input logic               rst_n,
  abs_stream_sched_if.slave bus
);

  localparam int unsigned      ChW      = $clog2(NCH);
  localparam int unsigned      CntW     = LOG_LEN + 1;
  localparam int unsigned      WarmW    = $clog2(WARM + 1);
  localparam logic [CntW-1:0]  LastWin  = CntW'((2 ** LOG_LEN) - 1);
  localparam logic [WarmW-1:0] LastWarm = WarmW'(WARM - 1);

  sched_state_t     state_q, state_d;
  logic [ChW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ChW-1:0]   sel_q, sel_d, sel_next;
  logic [ChW-1:0]   done_ch_q, done_ch_d;
  logic [NCH-1:0]   gnt_q, gnt_d;
  logic [CntW-1:0]  win_cnt_q, win_cnt_d;
  logic [CntW-1:0]  ones_cnt_q, ones_cnt_d;
  logic [CntW-1:0]  result_q, result_d;
  logic [WarmW-1:0] warm_cnt_q, warm_cnt_d;
  logic             done_q, done_d;
  logic             est_clr, est_en, est_sign, est_abs;
  logic             pick_found;
  int unsigned      pick_idx;
  logic [ChW-1:0]   pick_sel;

  always_comb begin
    pick_idx   = 0;
    pick_found = rr_pick(MaxCh'(bus.req), NCH, 32'(rr_ptr_q), pick_idx);
  end

  assign pick_sel = ChW'(pick_idx);
  assign sel_next = (sel_q == ChW'(NCH - 1)) ? '0 : sel_q + 1'b1;
  assign est_clr  = (state_q == StArb);
  assign est_en   = (state_q == StWarm) || (state_q == StRun);

  abs_sign_est #(
    .DEP(DEP)
  ) u_est (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (est_clr),
    .en   (est_en),
    .value(bus.value[sel_q]),
    .sign (est_sign),
    .abs  (est_abs)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    sel_d      = sel_q;
    gnt_d      = gnt_q;
    win_cnt_d  = win_cnt_q;
    warm_cnt_d = warm_cnt_q;
    ones_cnt_d = ones_cnt_q;
    result_d   = result_q;
    done_ch_d  = done_ch_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|bus.req) state_d = StArb;
      end
      StArb: begin
        win_cnt_d  = '0;
        warm_cnt_d = '0;
        ones_cnt_d = '0;
        if (pick_found) begin
          sel_d   = pick_sel;
          gnt_d   = NCH'(1) << pick_sel;
          state_d = StWarm;
        end else begin
          state_d = StIdle;
        end
      end
      StWarm: begin
        if (!bus.req[sel_q]) begin
          state_d  = StIdle;
          gnt_d    = '0;
          rr_ptr_d = sel_next;
        end else if (warm_cnt_q == LastWarm) begin
          state_d = StRun;
        end else begin
          warm_cnt_d = warm_cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (!bus.req[sel_q]) begin
          state_d  = StIdle;
          gnt_d    = '0;
          rr_ptr_d = sel_next;
        end else begin
          ones_cnt_d = ones_cnt_q + CntW'(est_abs);
          if (win_cnt_q == LastWin) state_d = StDone;
          else                      win_cnt_d = win_cnt_q + 1'b1;
        end
      end
      StDone: begin
        done_d    = 1'b1;
        result_d  = ones_cnt_q;
        done_ch_d = sel_q;
        rr_ptr_d  = sel_next;
        gnt_d     = '0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      sel_q      <= '0;
      gnt_q      <= '0;
      win_cnt_q  <= '0;
      warm_cnt_q <= '0;
      ones_cnt_q <= '0;
      result_q   <= '0;
      done_ch_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      sel_q      <= sel_d;
      gnt_q      <= gnt_d;
      win_cnt_q  <= win_cnt_d;
      warm_cnt_q <= warm_cnt_d;
      ones_cnt_q <= ones_cnt_d;
      result_q   <= result_d;
      done_ch_q  <= done_ch_d;
      done_q     <= done_d;
    end
  end

`ifdef ABS_SCHED_SIGN_OUT_EN
  localparam logic [CntW-1:0] HalfWin = CntW'(2 ** (LOG_LEN - 1));

  logic [CntW-1:0] sgn_cnt_q, sgn_cnt_d;
  logic            neg_q, neg_d;

  always_comb begin
    sgn_cnt_d = sgn_cnt_q;
    neg_d     = neg_q;
    if (state_q == StArb) begin
      sgn_cnt_d = '0;
    end else if (state_q == StRun && bus.req[sel_q]) begin
      sgn_cnt_d = sgn_cnt_q + CntW'(est_sign);
    end else if (state_q == StDone) begin
      neg_d = (sgn_cnt_q >= HalfWin);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn_cnt_q <= '0;
      neg_q     <= 1'b0;
    end else begin
      sgn_cnt_q <= sgn_cnt_d;
      neg_q     <= neg_d;
    end
  end

  assign bus.neg = neg_q;
`else
  logic unused_sign;
  assign unused_sign = est_sign;
`endif

  assign bus.gnt     = gnt_q;
  assign bus.abs_bit = est_en & est_abs;
  assign bus.busy    = (state_q != StIdle);
  assign bus.done    = done_q;
  assign bus.done_ch = done_ch_q;
  assign bus.result  = result_q;

endmodule

// File: tb/tb_abs_stream_sched.sv
// Randomized self-checking bench for abs_stream_sched with a timeline-based reference model.
module tb_abs_stream_sched;

  localparam int unsigned NCH     = 4;
  localparam int unsigned LOG_LEN = 4;
  localparam int unsigned WARM    = 4;
  localparam int unsigned DEP     = 3;
  localparam int          LEN     = 16;
  localparam int          MID     = 4;
  localparam int          CNTMAX  = 7;
  localparam int          CNTW    = LOG_LEN + 1;

  logic clk = 1'b0;
  logic rst_n;

  abs_stream_sched_if #(.NCH(NCH), .LOG_LEN(LOG_LEN)) bus ();

  abs_stream_sched #(
    .NCH    (NCH),
    .LOG_LEN(LOG_LEN),
    .WARM   (WARM),
    .DEP    (DEP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int              checks   = 0;
  int              failures = 0;
  int              model_ptr = 0;
  logic [CNTW-1:0] last_result = '0;

  function automatic int model_pick(input logic [NCH-1:0] r, input int ptr);
    for (int i = 0; i < NCH; i++) begin
      if (r[(ptr + i) % NCH]) return (ptr + i) % NCH;
    end
    return -1;
  endfunction

  function automatic logic stream_bit(input int mode, input int k);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return ((k % 4) < 2);
      default: return 1'($urandom);
    endcase
  endfunction

  // One complete job on channel ch, entered just after a negedge with the DUT idle.
  task automatic run_job(input int ch, input int mode);
    int             cnt, ones, negs, last_c;
    logic           vbit, sgn, exp_abs, exp_busy, exp_done;
    logic [NCH-1:0] onehot, exp_gnt, v;
    logic [1:0]     exp_ch;
    cnt    = MID;
    ones   = 0;
    negs   = 0;
    onehot = NCH'(1) << ch;
    exp_ch = 2'(ch);
    last_c = 2 + WARM + LEN + 1;
    for (int c = 0; c <= last_c; c++) begin
      if (c == 0) bus.req = onehot;
      if (c == last_c) bus.req = '0;
      vbit = (c >= 2 && c < 2 + WARM + LEN) ? stream_bit(mode, c - 2) : 1'($urandom);
      v = NCH'($urandom);
      v[ch] = vbit;
      bus.value = v;
      #1;
      exp_gnt  = (c >= 2 && c <= 2 + WARM + LEN) ? onehot : '0;
      exp_busy = (c >= 1 && c <= 2 + WARM + LEN);
      exp_done = (c == last_c);
      exp_abs  = 1'b0;
      if (c >= 2 && c < 2 + WARM + LEN) begin
        sgn     = (cnt < MID);
        exp_abs = vbit ^ sgn;
        if (c >= 2 + WARM) begin
          ones += int'(exp_abs);
          negs += int'(sgn);
        end
        if (vbit) cnt = (cnt < CNTMAX) ? cnt + 1 : cnt;
        else      cnt = (cnt > 0) ? cnt - 1 : cnt;
      end
      checks++;
      if (bus.gnt !== exp_gnt)
        begin failures++; $display("FAIL job_gnt ch=%0d c=%0d got=%b exp=%b", ch, c, bus.gnt, exp_gnt); end
      checks++;
      if (bus.busy !== exp_busy)
        begin failures++; $display("FAIL job_busy ch=%0d c=%0d got=%b exp=%b", ch, c, bus.busy, exp_busy); end
      checks++;
      if (bus.done !== exp_done)
        begin failures++; $display("FAIL job_done ch=%0d c=%0d got=%b exp=%b", ch, c, bus.done, exp_done); end
      checks++;
      if (bus.abs_bit !== exp_abs)
        begin failures++; $display("FAIL job_abs ch=%0d c=%0d got=%b exp=%b", ch, c, bus.abs_bit, exp_abs); end
      if (exp_done) begin
        checks++;
        if (bus.result !== CNTW'(ones))
          begin failures++; $display("FAIL job_result ch=%0d got=%0d exp=%0d", ch, bus.result, ones); end
        checks++;
        if (bus.done_ch !== exp_ch)
          begin failures++; $display("FAIL job_done_ch got=%0d exp=%0d", bus.done_ch, exp_ch); end
`ifdef ABS_SCHED_SIGN_OUT_EN
        checks++;
        if (bus.neg !== (negs >= LEN / 2))
          begin failures++; $display("FAIL job_neg ch=%0d got=%b negs=%0d", ch, bus.neg, negs); end
`endif
      end
      @(negedge clk);
    end
    model_ptr   = (ch + 1) % NCH;
    last_result = CNTW'(ones);
  endtask

  task automatic check_outputs_zero(input string tag);
    checks++;
    if (bus.gnt !== '0) begin failures++; $display("FAIL %s_gnt got=%b exp=0", tag, bus.gnt); end
    checks++;
    if (bus.abs_bit !== 1'b0) begin failures++; $display("FAIL %s_abs got=%b exp=0", tag, bus.abs_bit); end
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL %s_busy got=%b exp=0", tag, bus.busy); end
    checks++;
    if (bus.done !== 1'b0) begin failures++; $display("FAIL %s_done got=%b exp=0", tag, bus.done); end
    checks++;
    if (bus.done_ch !== '0) begin failures++; $display("FAIL %s_done_ch got=%0d exp=0", tag, bus.done_ch); end
    checks++;
    if (bus.result !== '0) begin failures++; $display("FAIL %s_result got=%0d exp=0", tag, bus.result); end
`ifdef ABS_SCHED_SIGN_OUT_EN
    checks++;
    if (bus.neg !== 1'b0) begin failures++; $display("FAIL %s_neg got=%b exp=0", tag, bus.neg); end
`endif
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.req   = '0;
    bus.value = '0;
    repeat (2) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    model_ptr   = 0;
    last_result = '0;
    @(negedge clk);
  endtask

  task automatic test_const_one();
    run_job(0, 1);
    checks++;
    if (bus.result !== CNTW'(LEN))
      begin failures++; $display("FAIL const_one_result got=%0d exp=%0d", bus.result, LEN); end
`ifdef ABS_SCHED_SIGN_OUT_EN
    checks++;
    if (bus.neg !== 1'b0) begin failures++; $display("FAIL const_one_neg got=%b exp=0", bus.neg); end
`endif
  endtask

  task automatic test_const_zero();
    run_job(1, 0);
    checks++;
    if (bus.result !== CNTW'(LEN))
      begin failures++; $display("FAIL const_zero_result got=%0d exp=%0d", bus.result, LEN); end
`ifdef ABS_SCHED_SIGN_OUT_EN
    checks++;
    if (bus.neg !== 1'b1) begin failures++; $display("FAIL const_zero_neg got=%b exp=1", bus.neg); end
`endif
  endtask

  task automatic test_alternating();
    run_job(1, 2);
    checks++;
    if (bus.result < CNTW'(LEN / 2 - 2) || bus.result > CNTW'(LEN / 2 + 2))
      begin failures++; $display("FAIL alt_result got=%0d exp=8+-2", bus.result); end
    checks++;
    if (bus.done_ch !== 2'd1) begin failures++; $display("FAIL alt_done_ch got=%0d exp=1", bus.done_ch); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) run_job(int'($urandom_range(NCH - 1)), 3);
  endtask

  task automatic test_abort();
    int             abort_c, exp_pick;
    logic [NCH-1:0] exp_gnt;
    abort_c = 2 + WARM + 5;
    bus.req = 4'b0100;
    for (int c = 0; c < abort_c; c++) begin
      bus.value = NCH'($urandom);
      @(negedge clk);
    end
    bus.req   = 4'b1001;
    model_ptr = 3;
    @(negedge clk);
    #1;
    checks++;
    if (bus.gnt !== '0) begin failures++; $display("FAIL abort_gnt got=%b exp=0", bus.gnt); end
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    checks++;
    if (bus.result !== last_result)
      begin failures++; $display("FAIL abort_result got=%0d exp=%0d", bus.result, last_result); end
    repeat (2) begin
      checks++;
      if (bus.done !== 1'b0) begin failures++; $display("FAIL abort_no_done got=%b exp=0", bus.done); end
      @(negedge clk);
      #1;
    end
    exp_pick = model_pick(bus.req, model_ptr);
    exp_gnt  = NCH'(1) << exp_pick;
    checks++;
    if (bus.gnt !== exp_gnt) begin failures++; $display("FAIL abort_next_gnt got=%b exp=%b", bus.gnt, exp_gnt); end
    bus.req   = '0;
    model_ptr = (exp_pick + 1) % NCH;
    @(negedge clk);
    #1;
    checks++;
    if (bus.gnt !== '0) begin failures++; $display("FAIL abort2_gnt got=%b exp=0", bus.gnt); end
    checks++;
    if (bus.done !== 1'b0) begin failures++; $display("FAIL abort2_done got=%b exp=0", bus.done); end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int         n_done, exp_pick;
    logic [1:0] exp_ch;
    n_done    = 0;
    bus.req   = '1;
    bus.value = '1;
    for (int c = 0; c < 5 * (WARM + LEN + 3) + 20 && n_done < 5; c++) begin
      #1;
      checks++;
      if (!$onehot0(bus.gnt)) begin failures++; $display("FAIL rr_onehot c=%0d got=%b", c, bus.gnt); end
      if (bus.done === 1'b1) begin
        exp_pick  = model_pick(4'b1111, model_ptr);
        exp_ch    = 2'(exp_pick);
        model_ptr = (exp_pick + 1) % NCH;
        checks++;
        if (bus.done_ch !== exp_ch)
          begin failures++; $display("FAIL rr_done_ch n=%0d got=%0d exp=%0d", n_done, bus.done_ch, exp_ch); end
        checks++;
        if (bus.result !== CNTW'(LEN))
          begin failures++; $display("FAIL rr_result n=%0d got=%0d exp=%0d", n_done, bus.result, LEN); end
        n_done++;
        if (n_done == 5) bus.req = '0;
      end
      @(negedge clk);
    end
    bus.req = '0;
    checks++;
    if (n_done != 5) begin failures++; $display("FAIL rr_timeout dones=%0d exp=5", n_done); end
    last_result = CNTW'(LEN);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bus.req = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      bus.value = NCH'($urandom);
      @(negedge clk);
    end
    rst_n   = 1'b0;
    bus.req = '0;
    #1;
    check_outputs_zero("reset_mid");
    @(negedge clk);
    rst_n       = 1'b1;
    model_ptr   = 0;
    last_result = '0;
    @(negedge clk);
    run_job(0, 3);
  endtask

  initial begin
    test_reset();
    test_const_one();
    test_const_zero();
    test_alternating();
    test_random();
    test_abort();
    test_round_robin();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
